// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw switch/button inputs and conditioned command outputs
interface input_conditioner_if;
  logic [3:0] sw_raw;
  logic       step_raw;
  logic [3:0] ext_input;
  logic       step_pulse;
  logic [3:0] sw_stable;
  logic [7:0] press_count;

  modport master (
    output sw_raw,
    output step_raw,
    input  ext_input,
    input  step_pulse,
    input  sw_stable,
    input  press_count
  );

  modport slave (
    input  sw_raw,
    input  step_raw,
    output ext_input,
    output step_pulse,
    output sw_stable,
    output press_count
  );
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronize, debounce and latch switch command on step presses
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input_conditioner_if.slave    bus
);

  localparam logic [19:0] CNT_LAST    = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] CNT_MAX     = 20'(DEBOUNCE_CYCLES);
  localparam logic [19:0] CNT_PRELOAD = 20'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Bit 4 carries the step button, bits 3:0 the switches.
  logic [4:0]  sync_q [SYNC_STAGES];
  logic [3:0]  sw_sync;
  logic        step_sync;

  logic [3:0]  sw_prev_q;
  logic [19:0] sw_cnt_q;
  logic [3:0]  sw_stable_q;
  logic        sw_changed;

  state_t      state_q;
  state_t      state_d;
  logic [19:0] step_cnt_q;
  logic        step_cnt_clr;
  logic        step_cnt_inc;
  logic        accept;

  logic        step_pulse_q;
  logic [3:0]  ext_input_q;
  logic [7:0]  press_count_q;

  assign sw_sync    = sync_q[SYNC_STAGES-1][3:0];
  assign step_sync  = sync_q[SYNC_STAGES-1][4];
  assign sw_changed = (sw_sync != sw_prev_q);

  // Synchronizer chain shared by all five raw inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.step_raw, bus.sw_raw};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Switch debounce: one counter for the whole vector, any bit change restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_prev_q   <= '0;
      sw_cnt_q    <= '0;
      sw_stable_q <= '0;
    end else begin
      sw_prev_q <= sw_sync;
      if (sw_changed) begin
        sw_cnt_q <= '0;
      end else if (sw_cnt_q < CNT_MAX) begin
        sw_cnt_q <= sw_cnt_q + 20'd1;
        if (sw_cnt_q == CNT_PRELOAD) sw_stable_q <= sw_sync;
      end
    end
  end

  // Step FSM next-state and counter control.
  always_comb begin
    state_d      = state_q;
    step_cnt_clr = 1'b0;
    step_cnt_inc = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_sync) begin
          state_d      = PRESS_WAIT;
          step_cnt_clr = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (!step_sync) begin
          state_d = IDLE;
        end else if (step_cnt_q == CNT_LAST) begin
          state_d = HELD;
          accept  = 1'b1;
        end else begin
          step_cnt_inc = 1'b1;
        end
      end
      HELD: begin
        if (!step_sync) begin
          state_d      = RELEASE_WAIT;
          step_cnt_clr = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (step_sync) begin
          state_d = HELD;
        end else if (step_cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          step_cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Step FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Step debounce counter.
  always_ff @(posedge clk) begin
    if (!reset)            step_cnt_q <= '0;
    else if (step_cnt_clr) step_cnt_q <= '0;
    else if (step_cnt_inc) step_cnt_q <= step_cnt_q + 20'd1;
  end

  // Accepted press: strobe, latch the debounced switches, bump the press count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_pulse_q  <= 1'b0;
      ext_input_q   <= '0;
      press_count_q <= '0;
    end else begin
      step_pulse_q <= accept;
      if (accept) begin
        ext_input_q   <= sw_stable_q;
        press_count_q <= press_count_q + 8'd1;
      end
    end
  end

  assign bus.step_pulse  = step_pulse_q;
  assign bus.ext_input   = ext_input_q;
  assign bus.sw_stable   = sw_stable_q;
  assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed and randomized checks of input_conditioner against a level/run-length model
module tb_input_conditioner;
  localparam int D = 8;
  localparam int S = 2;

  logic clk;
  logic reset;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int last_pulse_cyc = -1;

  // Model: input delay line, switch run length, accepted button level plus
  // run length of edges whose synchronized level disagrees with it.
  logic [4:0] m_dl [S];
  logic [3:0] m_prev_sw;
  logic [3:0] m_stable;
  logic [3:0] m_ext;
  logic [7:0] m_cnt;
  logic       m_acc;
  logic       m_pulse;
  int         m_sw_run;
  int         m_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [4:0] cur;
    if (!reset) begin
      for (int i = 0; i < S; i++) m_dl[i] = '0;
      m_prev_sw = '0; m_stable = '0; m_ext = '0; m_cnt = '0;
      m_acc = 1'b0; m_pulse = 1'b0; m_sw_run = 0; m_run = 0;
    end else begin
      cur = m_dl[S-1];
      for (int i = S-1; i > 0; i--) m_dl[i] = m_dl[i-1];
      m_dl[0] = {bus.step_raw, bus.sw_raw};
      m_pulse = 1'b0;
      // Button: D+1 consecutive disagreeing edges flip the accepted level.
      if (cur[4] == m_acc) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == D + 1) begin
          m_acc = cur[4];
          m_run = 0;
          if (m_acc) begin
            m_pulse = 1'b1;
            m_ext   = m_stable;
            m_cnt   = m_cnt + 8'd1;
          end
        end
      end
      // Switches: adopt once unchanged for D-1 consecutive comparisons.
      if (cur[3:0] != m_prev_sw) begin
        m_sw_run = 0;
      end else if (m_sw_run < D) begin
        m_sw_run++;
        if (m_sw_run == D - 1) m_stable = cur[3:0];
      end
      m_prev_sw = cur[3:0];
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.step_pulse === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
    end
    check("step_pulse", 32'(bus.step_pulse), 32'(m_pulse));
    check("ext_input", 32'(bus.ext_input), 32'(m_ext));
    check("sw_stable", 32'(bus.sw_stable), 32'(m_stable));
    check("press_count", 32'(bus.press_count), 32'(m_cnt));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int start;
    int p0;
    int rel;
    reset = 1'b0;
    bus.sw_raw = '0;
    bus.step_raw = 1'b0;

    // Reset with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      bus.sw_raw   = 4'($urandom);
      bus.step_raw = 1'($urandom);
      tick();
    end
    check("rst_ext_input", 32'(bus.ext_input), 32'h0);
    check("rst_sw_stable", 32'(bus.sw_stable), 32'h0);
    check("rst_step_pulse", 32'(bus.step_pulse), 32'h0);
    check("rst_press_count", 32'(bus.press_count), 32'h0);

    // Clean press with switches at A.
    reset = 1'b1;
    bus.sw_raw = 4'hA;
    bus.step_raw = 1'b0;
    ticks(20);
    p0 = pulses;
    start = cyc;
    bus.step_raw = 1'b1;
    ticks(30);
    check("clean_pulse_count", 32'(pulses - p0), 32'd1);
    check("clean_latency", 32'(last_pulse_cyc - start), 32'd11);
    check("clean_ext_input", 32'(bus.ext_input), 32'hA);
    check("clean_press_count", 32'(bus.press_count), 32'd1);
    bus.step_raw = 1'b0;
    ticks(20);

    // Bouncing button never qualifies.
    p0 = pulses;
    for (int i = 0; i < 40; i++) begin
      bus.step_raw = ((i / 3) % 2) == 0;
      tick();
    end
    bus.step_raw = 1'b0;
    ticks(20);
    check("bounce_pulses", 32'(pulses - p0), 32'd0);
    check("bounce_ext_input", 32'(bus.ext_input), 32'hA);
    check("bounce_press_count", 32'(bus.press_count), 32'd1);

    // Switch change without a press.
    bus.sw_raw = 4'h5;
    ticks(9);
    check("sw_before_accept", 32'(bus.sw_stable), 32'hA);
    tick();
    check("sw_after_10", 32'(bus.sw_stable), 32'h5);
    check("sw_ext_unchanged", 32'(bus.ext_input), 32'hA);
    ticks(10);

    // Reset in the middle of PRESS_WAIT while the button stays down.
    p0 = pulses;
    start = cyc;
    bus.step_raw = 1'b1;
    ticks(8);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rel = cyc;
    ticks(25);
    check("midrst_pulses", 32'(pulses - p0), 32'd1);
    check("midrst_latency", 32'(last_pulse_cyc - rel), 32'd11);
    check("midrst_not_original", 32'(last_pulse_cyc != start + 11), 32'd1);
    check("midrst_press_count", 32'(bus.press_count), 32'd1);
    bus.step_raw = 1'b0;
    ticks(20);

    // Wrap press_count through 256 presses.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 256; i++) begin
      bus.sw_raw = 4'($urandom);
      bus.step_raw = 1'b1;
      ticks(12);
      bus.step_raw = 1'b0;
      ticks(12);
      if (i == 254) check("wrap_255", 32'(bus.press_count), 32'd255);
    end
    check("wrap_pulses", 32'(pulses - p0), 32'd256);
    check("wrap_press_count", 32'(bus.press_count), 32'd0);

    // Random segments of switch and button activity.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) bus.sw_raw = 4'($urandom);
      bus.step_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) reset = 1'b0;
      ticks($urandom_range(1, 14));
      reset = 1'b1;
    end
    bus.step_raw = 1'b0;
    ticks(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
